time_entry_register: RTL

- Stage directly downstream of priority_encoder in the microwave keypad path.
- Consumes the encoder's digit/loadn pair and shifts each new key press into a 4-digit BCD cook-time register (MM:SS, entered right-to-left like a microwave keypad).
- Drives the encoder's enablen so that no new keys are accepted while the register is full or the controller has locked entry.
- Its outputs feed the countdown timer and the display.

---
 rtl/microwave_pkg.sv | 20 ++
 rtl/key_sync_edge.sv | 63 ++++++
 rtl/time_entry_register.sv | 77 +++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared microwave keypad-path constants and the BCD cook-time types.
// TIME_ENTRY_DEBOUNCE_EN (in key_sync_edge) uses DEBOUNCE_CYCLES and DB_CNT_W.
package microwave_pkg;

  localparam int unsigned BCD_W           = 4;
  localparam int unsigned NUM_DIGITS      = 4;
  localparam int unsigned BCD_MAX         = 9;
  localparam int unsigned CNT_W           = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned DB_CNT_W        = 3;

  localparam int unsigned SEC_ONES = 0;
  localparam int unsigned SEC_TENS = 1;
  localparam int unsigned MIN_ONES = 2;
  localparam int unsigned MIN_TENS = 3;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0] bcd_time_t;

endpackage

// File: rtl/key_sync_edge.sv
// Synchronizes loadn/digit into clk and produces a one-cycle press pulse.
// TIME_ENTRY_DEBOUNCE_EN: press only after DEBOUNCE_CYCLES consecutive low samples.
module key_sync_edge
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             loadn,
  input  logic [BCD_W-1:0] digit,
  output logic             press_c,
  output logic [BCD_W-1:0] digit_sync
);

  logic             loadn_meta;
  logic             loadn_sync;
  logic [BCD_W-1:0] digit_meta;

  // Digit rides the same two-flop path so it stays aligned with loadn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loadn_meta <= 1'b1;
      loadn_sync <= 1'b1;
      digit_meta <= '1;
      digit_sync <= '1;
    end else begin
      loadn_meta <= loadn;
      loadn_sync <= loadn_meta;
      digit_meta <= digit;
      digit_sync <= digit_meta;
    end
  end

`ifdef TIME_ENTRY_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_cnt;
  logic [DB_CNT_W-1:0] db_cnt_next;

  // Count consecutive low samples, saturating at the threshold
  always_comb begin
    db_cnt_next = '0;
    if (!loadn_sync) begin
      db_cnt_next = (db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES)) ? db_cnt : db_cnt + DB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) db_cnt <= '0;
    else         db_cnt <= db_cnt_next;
  end

  assign press_c = (db_cnt_next == DB_CNT_W'(DEBOUNCE_CYCLES)) &&
                   (db_cnt != DB_CNT_W'(DEBOUNCE_CYCLES));
`else
  logic loadn_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) loadn_prev <= 1'b1;
    else         loadn_prev <= loadn_sync;
  end

  assign press_c = loadn_prev && !loadn_sync;
`endif

endmodule

// File: rtl/time_entry_register.sv
// 4-digit BCD MM:SS cook-time entry register fed by the keypad priority encoder.
// Optional TIME_ENTRY_DEBOUNCE_EN debounces loadn inside key_sync_edge.
module time_entry_register
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [BCD_W-1:0] digit,
  input  logic             loadn,
  input  logic             clearn,
  input  logic             lock,
  output logic             enablen,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             zero
);

  logic             press_c;
  logic [BCD_W-1:0] digit_sync;
  logic             capture_c;
  bcd_time_t        digits_q;
  bcd_time_t        digits_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             enablen_d;

  key_sync_edge u_key_sync_edge (
    .clk        (clk),
    .resetn     (resetn),
    .loadn      (loadn),
    .digit      (digit),
    .press_c    (press_c),
    .digit_sync (digit_sync)
  );

  assign full = (count_q == CNT_W'(NUM_DIGITS));
  assign zero = (digits_q == '0);

  assign capture_c = press_c && !lock && !full && (digit_sync <= BCD_W'(BCD_MAX));

  // Clear beats capture; capture shifts the new digit in at the seconds end
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (!clearn) begin
      digits_d = '0;
      count_d  = '0;
    end else if (capture_c) begin
      digits_d = {digits_q[NUM_DIGITS-2:0], digit_sync};
      count_d  = count_q + CNT_W'(1);
    end
    enablen_d = lock || (count_d == CNT_W'(NUM_DIGITS));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q <= '0;
      count_q  <= '0;
      enablen  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      enablen  <= enablen_d;
    end
  end

  assign sec_ones = digits_q[SEC_ONES];
  assign sec_tens = digits_q[SEC_TENS];
  assign min_ones = digits_q[MIN_ONES];
  assign min_tens = digits_q[MIN_TENS];
  assign count    = count_q;

endmodule
